dose_actuator: RTL and testbench
================================

Name: dose_actuator

Overview:
- Downstream consumer of the dispense-time slot pulses; one instance per pill compartment.
- Accepts morning/afternoon/evening dose requests for the slots it serves and drives the compartment's GPIO motor line for a fixed actuation window.
- Confirms the drop through an IR drop sensor, tracks the remaining pill count, and raises a sticky missed-dose alarm on an empty compartment or sensor timeout.

Parameters:
- ACTUATE_CYCLES, 50000000: motor-on duration in clock cycles (1 s at 50 MHz).
- SENSE_TIMEOUT, 100000000: cycles allowed in WAIT_DROP for drop confirmation.
- PILL_CAP, 30: count loaded by refill; must be at most 63.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- morningP  in  1  single-cycle dose request, slot 0.
- afternoonP  in  1  single-cycle dose request, slot 1.
- eveningP  in  1  single-cycle dose request, slot 2.
- slotEnable  in  3  per-slot service mask; bit0 = morning.
- refill  in  1  single-cycle pulse; loads pillCount with PILL_CAP.
- clearAlarm  in  1  single-cycle pulse; clears missedDose.
- dropSensor  in  1  asynchronous IR sensor, high = pill present.
- motor  out  1  registered GPIO actuator drive.
- busy  out  1  high in any state other than IDLE.
- pillCount  out  6  remaining pills.
- empty  out  1  high when pillCount is 0.
- missedDose  out  1  sticky alarm.
- doseDone  out  1  single-cycle pulse on confirmed dose.

Behaviour:
- Reset (asynchronous, while reset = 0): state IDLE, motor 0, busy 0, pending 0, pillCount 0 (so empty = 1), missedDose 0, doseDone 0, all timers 0, synchronizer flops 0.
- Request capture:
  - pending[i] is set on any edge where slot pulse i = 1 and slotEnable[i] = 1.
  - Pulses on disabled slots are ignored.
  - Capture happens in every state, so requests arriving while busy are queued.
  - A slot already pending stays a single request; requests are not counted.
- IDLE:
  - If pending is nonzero, select the lowest set index (morning > afternoon > evening) and clear that bit.
  - If pillCount = 0: set missedDose and stay in IDLE, with no actuation.
  - Otherwise: go to ACTUATE, set motor to 1 on the same edge, clear the timer and dropSeen.
  - Latency: pulse sampled at edge t, pending set at t; motor rises at edge t+1.
- ACTUATE:
  - motor stays high for exactly ACTUATE_CYCLES cycles.
  - At timer = ACTUATE_CYCLES-1, go to WAIT_DROP, drive motor to 0 and clear the timer.
- Drop detection:
  - dropSensor passes through a 2-flop synchronizer, then a rising-edge detector.
  - An edge seen in ACTUATE or WAIT_DROP sets dropSeen.
  - Edges seen in IDLE or DONE are ignored.
- WAIT_DROP:
  - If dropSeen is set (including an edge arriving this cycle), go to DONE and decrement pillCount, saturating at 0.
  - Else if timer = SENSE_TIMEOUT-1, set missedDose, leave pillCount unchanged, and go to IDLE.
- DONE: doseDone = 1 for exactly one cycle, then go to IDLE.
- refill:
  - Loads PILL_CAP in any state.
  - If refill coincides with a decrement, refill wins.
  - refill does not clear missedDose.
- clearAlarm:
  - Clears missedDose.
  - If an alarm set-event occurs on the same edge, set wins.
- Width rules: timers are 27 bits, unsigned compare only; pillCount never wraps below 0.
- Reset mid-actuation: motor drops to 0 immediately (asynchronous); any queued requests are lost.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, ACTUATE = 2'd1, WAIT_DROP = 2'd2, DONE = 2'd3;
  - slot index constants: MORNING = 0, AFTERNOON = 1, EVENING = 2;
  - TIMER_W = 27.
- One sub-module, sensor_edge_sync: 2-flop synchronizer plus rising-edge pulse, with the same clock and asynchronous active-low reset.

Test Plan:
All scenarios use ACTUATE_CYCLES = 8, SENSE_TIMEOUT = 16, PILL_CAP = 3.
1. Release reset, pulse refill, then pulse morningP with slotEnable = 3'b001; raise dropSensor 3 cycles after motor falls -> motor high exactly 8 cycles starting 1 cycle after the pulse; doseDone pulses once; pillCount goes 3 -> 2.
2. Pulse afternoonP with slotEnable = 3'b001 -> no motor activity, busy stays 0, pending stays 0.
3. During ACTUATE, pulse eveningP and afternoonP with slotEnable = 3'b111 -> two further actuations follow back-to-back through IDLE, afternoon first, then evening.
4. Actuate with dropSensor held low -> missedDose = 1 exactly 16 cycles after motor falls; pillCount unchanged; clearAlarm returns missedDose to 0.
5. Issue three confirmed doses, then a fourth request -> pillCount = 0, empty = 1, missedDose = 1, motor never rises for the fourth request; refill then gives pillCount = 3 while missedDose stays 1.
6. Assert reset 4 cycles into ACTUATE with pending = 3'b100 -> motor goes to 0 without waiting for a clock edge; all outputs return to their reset values; no actuation after reset is released.

Source files
------------

// File: rtl/dose_actuator_pkg.sv
// dose_actuator_pkg
//   Shared definitions for the per-compartment dose actuator: FSM state
//   encoding, slot index constants, timer width and the request arbiter.
package dose_actuator_pkg;

  localparam int TIMER_W   = 27;

  localparam int MORNING   = 0;
  localparam int AFTERNOON = 1;
  localparam int EVENING   = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTUATE   = 2'd1,
    WAIT_DROP = 2'd2,
    DONE      = 2'd3
  } state_t;

  // One-hot mask of the lowest set request bit (morning has priority).
  function automatic logic [2:0] lowest_set(input logic [2:0] req);
    logic [2:0] mask;
    mask = 3'b000;
    if (req[MORNING])        mask[MORNING]   = 1'b1;
    else if (req[AFTERNOON]) mask[AFTERNOON] = 1'b1;
    else if (req[EVENING])   mask[EVENING]   = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/dose_actuator_if.sv
// dose_actuator_if
//   Bundles the dose request inputs, sensor input and status outputs of one
//   pill compartment.
//   master : dose scheduler / board side (drives requests, sensor)
//   slave  : dose_actuator (drives motor and status)
interface dose_actuator_if;
  logic       morningP;
  logic       afternoonP;
  logic       eveningP;
  logic [2:0] slotEnable;
  logic       refill;
  logic       clearAlarm;
  logic       dropSensor;
  logic       motor;
  logic       busy;
  logic [5:0] pillCount;
  logic       empty;
  logic       missedDose;
  logic       doseDone;

  modport master (
    output morningP, afternoonP, eveningP, slotEnable, refill, clearAlarm, dropSensor,
    input  motor, busy, pillCount, empty, missedDose, doseDone
  );

  modport slave (
    input  morningP, afternoonP, eveningP, slotEnable, refill, clearAlarm, dropSensor,
    output motor, busy, pillCount, empty, missedDose, doseDone
  );
endinterface

// File: rtl/dose_actuator_sensor_edge_sync.sv
// sensor_edge_sync
//   Brings the asynchronous IR drop sensor into the CLOCK_50 domain through a
//   2-flop synchronizer and produces a one-cycle pulse on its rising edge.
//   CLOCK_50     : system clock
//   reset        : asynchronous active-low reset
//   sensor_raw   : asynchronous sensor level
//   sensor_rise  : one-cycle pulse after a synchronized 0->1 transition
module sensor_edge_sync (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic sensor_raw,
  output logic sensor_rise
);

  logic sync_1, sync_2, sync_prev;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= sensor_raw;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign sensor_rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/dose_actuator.sv
// dose_actuator
//   Per-compartment dose actuator. Queues enabled slot requests, drives the
//   motor for a fixed window, confirms the drop via the IR sensor, tracks the
//   remaining pill count and raises a sticky missed-dose alarm.
//   CLOCK_50 : system clock (50 MHz)
//   reset    : asynchronous active-low reset
//   bus      : requests/sensor in, motor/status out (dose_actuator_if.slave)
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | waiting for a pending request; empty compartment -> alarm
//   ACTUATE   | motor on for ACTUATE_CYCLES cycles
//   WAIT_DROP | motor off, waiting up to SENSE_TIMEOUT cycles for a drop
//   DONE      | one-cycle doseDone pulse
module dose_actuator
  import dose_actuator_pkg::*;
#(
  parameter int ACTUATE_CYCLES = 50000000,
  parameter int SENSE_TIMEOUT  = 100000000,
  parameter int PILL_CAP       = 30
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  dose_actuator_if.slave bus
);

  localparam logic [TIMER_W-1:0] ACT_LAST   = TIMER_W'(ACTUATE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SENSE_LAST = TIMER_W'(SENSE_TIMEOUT - 1);
  localparam logic [5:0]         PILL_LOAD  = 6'(PILL_CAP);

  state_t             state_q, state_d;
  logic               motor_q, motor_d;
  logic [2:0]         pending_q, pending_d;
  logic [5:0]         pill_q, pill_d;
  logic               missed_q, missed_d;
  logic               drop_seen_q, drop_seen_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic       drop_rise;
  logic [2:0] capture;
  logic [2:0] sel;
  logic [2:0] clr_mask;
  logic       alarm_set;

  sensor_edge_sync u_sensor_sync (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .sensor_raw  (bus.dropSensor),
    .sensor_rise (drop_rise)
  );

  assign capture = {bus.eveningP, bus.afternoonP, bus.morningP} & bus.slotEnable;
  assign sel     = lowest_set(pending_q);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      motor_q     <= 1'b0;
      pending_q   <= 3'b000;
      pill_q      <= 6'd0;
      missed_q    <= 1'b0;
      drop_seen_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      motor_q     <= motor_d;
      pending_q   <= pending_d;
      pill_q      <= pill_d;
      missed_q    <= missed_d;
      drop_seen_q <= drop_seen_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    motor_d     = motor_q;
    timer_d     = timer_q;
    drop_seen_d = drop_seen_q;
    pill_d      = pill_q;
    clr_mask    = 3'b000;
    alarm_set   = 1'b0;

    // Drops only count while a dose is in flight.
    if ((state_q == ACTUATE || state_q == WAIT_DROP) && drop_rise)
      drop_seen_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          clr_mask = sel;
          if (pill_q == 6'd0) begin
            alarm_set = 1'b1;
          end else begin
            state_d     = ACTUATE;
            motor_d     = 1'b1;
            timer_d     = '0;
            drop_seen_d = 1'b0;
          end
        end
      end
      ACTUATE: begin
        if (timer_q == ACT_LAST) begin
          state_d = WAIT_DROP;
          motor_d = 1'b0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      WAIT_DROP: begin
        if (drop_seen_q || drop_rise) begin
          state_d = DONE;
          pill_d  = (pill_q == 6'd0) ? 6'd0 : pill_q - 6'd1;
        end else if (timer_q == SENSE_LAST) begin
          alarm_set = 1'b1;
          state_d   = IDLE;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new pulse on the slot being served re-queues it.
    pending_d = (pending_q & ~clr_mask) | capture;

    if (bus.refill) pill_d = PILL_LOAD;

    if (alarm_set)           missed_d = 1'b1;
    else if (bus.clearAlarm) missed_d = 1'b0;
    else                     missed_d = missed_q;
  end

  assign bus.motor      = motor_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.pillCount  = pill_q;
  assign bus.empty      = (pill_q == 6'd0);
  assign bus.missedDose = missed_q;
  assign bus.doseDone   = (state_q == DONE);

endmodule

// File: tb/tb_dose_actuator.sv
module tb_dose_actuator;

  logic CLOCK_50;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  dose_actuator_if bus ();

  dose_actuator #(
    .ACTUATE_CYCLES (8),
    .SENSE_TIMEOUT  (16),
    .PILL_CAP       (3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse one slot request; returns right after the edge where the motor
  // should rise (or where IDLE reacts).
  task automatic request(input int slot);
    if (slot == 0) bus.morningP = 1'b1;
    if (slot == 1) bus.afternoonP = 1'b1;
    if (slot == 2) bus.eveningP = 1'b1;
    tick();
    bus.morningP = 1'b0; bus.afternoonP = 1'b0; bus.eveningP = 1'b0;
    chk("motor_before_rise", bus.motor, 0);
    tick();
  endtask

  // Called right after the motor-rise edge; runs the remaining 7 motor-high
  // cycles and the falling edge. Optionally injects afternoon+evening pulses.
  task automatic actuate_window(input string tag, input bit inject);
    for (int i = 0; i < 7; i++) begin
      if (inject && i == 2) begin
        bus.afternoonP = 1'b1;
        bus.eveningP   = 1'b1;
      end
      tick();
      bus.afternoonP = 1'b0;
      bus.eveningP   = 1'b0;
      chk({tag, "_motor_on"}, bus.motor, 1);
    end
    tick();
    chk({tag, "_motor_off"}, bus.motor, 0);
    chk({tag, "_busy_wait"}, bus.busy, 1);
  endtask

  // Raises the sensor 3 cycles after motor fall; drop is confirmed 3 edges later.
  task automatic confirm_drop(input string tag, input logic [5:0] exp_pill);
    tick(); tick(); tick();
    bus.dropSensor = 1'b1;
    tick(); tick();
    chk({tag, "_done_early"}, bus.doseDone, 0);
    tick();
    chk({tag, "_done_pulse"}, bus.doseDone, 1);
    chk({tag, "_pill"}, bus.pillCount, exp_pill);
    tick();
    chk({tag, "_done_end"}, bus.doseDone, 0);
    chk({tag, "_idle"}, bus.busy, 0);
    bus.dropSensor = 1'b0;
  endtask

  task automatic pulse_refill();
    bus.refill = 1'b1;
    tick();
    bus.refill = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset = 1'b0;
    bus.morningP = 1'b0; bus.afternoonP = 1'b0; bus.eveningP = 1'b0;
    bus.slotEnable = 3'b000; bus.refill = 1'b0; bus.clearAlarm = 1'b0;
    bus.dropSensor = 1'b0;
    tick(); tick();
    chk("rst_motor", bus.motor, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pill", bus.pillCount, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_missed", bus.missedDose, 0);
    chk("rst_done", bus.doseDone, 0);
    reset = 1'b1;
    tick();

    // 1: single morning dose
    pulse_refill();
    chk("t1_refill", bus.pillCount, 3);
    chk("t1_not_empty", bus.empty, 0);
    bus.slotEnable = 3'b001;
    request(0);
    chk("t1_motor_rise", bus.motor, 1);
    chk("t1_busy", bus.busy, 1);
    actuate_window("t1", 1'b0);
    confirm_drop("t1", 6'd2);
    tick(); tick();

    // 2: disabled slot ignored
    bus.afternoonP = 1'b1;
    tick();
    bus.afternoonP = 1'b0;
    chk("t2_pending", dut.pending_q, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_motor", bus.motor, 0);
      chk("t2_busy", bus.busy, 0);
    end

    // 3: queued afternoon + evening, served back-to-back in priority order
    pulse_refill();
    chk("t3_refill", bus.pillCount, 3);
    bus.slotEnable = 3'b111;
    request(0);
    chk("t3_motor_rise0", bus.motor, 1);
    actuate_window("t3a", 1'b1);
    chk("t3_queued", dut.pending_q, 3'b110);
    confirm_drop("t3a", 6'd2);
    chk("t3_still_queued", dut.pending_q, 3'b110);
    tick();
    chk("t3_motor_rise1", bus.motor, 1);
    chk("t3_afternoon_first", dut.pending_q, 3'b100);
    actuate_window("t3b", 1'b0);
    confirm_drop("t3b", 6'd1);
    tick();
    chk("t3_motor_rise2", bus.motor, 1);
    chk("t3_evening_next", dut.pending_q, 3'b000);
    actuate_window("t3c", 1'b0);
    confirm_drop("t3c", 6'd0);
    tick(); tick();

    // 4: sensor timeout
    pulse_refill();
    request(0);
    chk("t4_motor_rise", bus.motor, 1);
    actuate_window("t4", 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("t4_missed_early", bus.missedDose, 0);
    chk("t4_busy_early", bus.busy, 1);
    tick();
    chk("t4_missed", bus.missedDose, 1);
    chk("t4_idle", bus.busy, 0);
    chk("t4_pill", bus.pillCount, 3);
    bus.clearAlarm = 1'b1;
    tick();
    bus.clearAlarm = 1'b0;
    chk("t4_cleared", bus.missedDose, 0);
    tick();

    // 5: run compartment empty, then a request with nothing left
    request(0);
    chk("t5_rise_a", bus.motor, 1);
    actuate_window("t5a", 1'b0);
    confirm_drop("t5a", 6'd2);
    request(0);
    chk("t5_rise_b", bus.motor, 1);
    actuate_window("t5b", 1'b0);
    confirm_drop("t5b", 6'd1);
    request(0);
    chk("t5_rise_c", bus.motor, 1);
    actuate_window("t5c", 1'b0);
    confirm_drop("t5c", 6'd0);
    chk("t5_empty", bus.empty, 1);
    chk("t5_missed_before", bus.missedDose, 0);
    request(0);
    chk("t5_no_motor", bus.motor, 0);
    chk("t5_missed", bus.missedDose, 1);
    chk("t5_pending_cleared", dut.pending_q, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_motor_quiet", bus.motor, 0);
    end
    pulse_refill();
    chk("t5_refill", bus.pillCount, 3);
    chk("t5_missed_sticky", bus.missedDose, 1);

    // 6: reset in the middle of actuation
    request(0);
    chk("t6_motor_rise", bus.motor, 1);
    bus.eveningP = 1'b1;
    tick();
    bus.eveningP = 1'b0;
    tick(); tick(); tick();
    chk("t6_pending", dut.pending_q, 3'b100);
    chk("t6_motor_on", bus.motor, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_motor_async", bus.motor, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_pill", bus.pillCount, 0);
    chk("t6_empty", bus.empty, 1);
    chk("t6_missed", bus.missedDose, 0);
    chk("t6_done", bus.doseDone, 0);
    chk("t6_pending_lost", dut.pending_q, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_no_actuation", bus.motor, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
